// File: rtl/traffic_light_ctrl_pkg.sv
// Shared types for the two-approach intersection controller.
// Covers the phase codes, the approach direction codes and the lamp bundle.
package traffic_light_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_NS_GREEN  = 3'd0,
        ST_NS_YELLOW = 3'd1,
        ST_ALL_RED   = 3'd2,
        ST_EW_GREEN  = 3'd3,
        ST_EW_YELLOW = 3'd4,
        ST_PED_WALK  = 3'd5,
        ST_FLASH     = 3'd6
    } state_t;

    typedef enum logic {
        DIR_NS = 1'b0,
        DIR_EW = 1'b1
    } dir_t;

    typedef struct packed {
        logic ns_red;
        logic ns_yellow;
        logic ns_green;
        logic ew_red;
        logic ew_yellow;
        logic ew_green;
        logic walk;
    } lamps_t;

    localparam lamps_t LAMPS_ALL_RED = '{ns_red: 1'b1, ew_red: 1'b1, default: 1'b0};

    function automatic state_t green_of(input dir_t dir);
        return (dir == DIR_EW) ? ST_EW_GREEN : ST_NS_GREEN;
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_tick_gen.sv
// One-cycle tick enable every TICK_DIV clocks; TICK_DIV=1 ticks on every cycle.
module tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int             W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0]   LAST = W'(TICK_DIV - 1);

    logic [W-1:0] div_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_reg <= '0;
        end else if (div_reg == LAST) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + W'(1);
        end
    end

    assign tick = (div_reg == LAST);

endmodule

// File: rtl/traffic_light_ctrl.sv
// NS/EW intersection sequencer with all-red clearance, latched pedestrian walk
// phase and night flash mode; lamps are registered from the next-state decode.
module traffic_light_ctrl
    import traffic_light_ctrl_pkg::*;
#(
    parameter int TICK_DIV     = 100_000_000,
    parameter int GREEN_TICKS  = 4,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
    parameter int PED_TICKS    = 6,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ped_req,
    input  logic       flash_mode,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    logic             tick;
    state_t           state_reg, state_next;
    dir_t             next_dir_reg, next_dir_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] cnt_last;
    logic             ped_pending_reg, ped_pending_next;
    logic             ped_ack_next;
    lamps_t           lamps_reg, lamps_next;
    logic             phase_done;
    logic             ped_enter;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        cnt_last = '0;
        case (state_reg)
            ST_NS_GREEN, ST_EW_GREEN:   cnt_last = CNT_W'(GREEN_TICKS - 1);
            ST_NS_YELLOW, ST_EW_YELLOW: cnt_last = CNT_W'(YELLOW_TICKS - 1);
            ST_ALL_RED:                 cnt_last = CNT_W'(ALLRED_TICKS - 1);
            ST_PED_WALK:                cnt_last = CNT_W'(PED_TICKS - 1);
            default:                    cnt_last = '0;
        endcase
    end

    assign phase_done = tick && (cnt_reg == cnt_last);

    always_comb begin
        state_next    = state_reg;
        next_dir_next = next_dir_reg;
        case (state_reg)
            ST_NS_GREEN:  if (phase_done) state_next = ST_NS_YELLOW;
            ST_NS_YELLOW: if (phase_done) begin
                state_next    = ST_ALL_RED;
                next_dir_next = DIR_EW;
            end
            ST_EW_GREEN:  if (phase_done) state_next = ST_EW_YELLOW;
            ST_EW_YELLOW: if (phase_done) begin
                state_next    = ST_ALL_RED;
                next_dir_next = DIR_NS;
            end
            // Flash beats a waiting pedestrian; the request stays latched through it.
            ST_ALL_RED: if (phase_done) begin
                if (flash_mode)           state_next = ST_FLASH;
                else if (ped_pending_reg) state_next = ST_PED_WALK;
                else                      state_next = green_of(next_dir_reg);
            end
            ST_PED_WALK: if (phase_done) state_next = green_of(next_dir_reg);
            ST_FLASH: if (tick && !flash_mode) begin
                state_next    = ST_ALL_RED;
                next_dir_next = DIR_NS;
            end
            default: state_next = ST_ALL_RED;
        endcase

        cnt_next = cnt_reg;
        if (state_next != state_reg) begin
            cnt_next = '0;
        end else if (tick && state_reg != ST_FLASH) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end

        ped_enter        = (state_next == ST_PED_WALK) && (state_reg != ST_PED_WALK);
        ped_ack_next     = ped_enter;
        ped_pending_next = ped_pending_reg;
        if (ped_enter) begin
            ped_pending_next = 1'b0;
        end else if (ped_req && state_reg != ST_PED_WALK) begin
            ped_pending_next = 1'b1;
        end

        lamps_next = LAMPS_ALL_RED;
        case (state_next)
            ST_NS_GREEN:  begin lamps_next.ns_red = 1'b0; lamps_next.ns_green  = 1'b1; end
            ST_NS_YELLOW: begin lamps_next.ns_red = 1'b0; lamps_next.ns_yellow = 1'b1; end
            ST_EW_GREEN:  begin lamps_next.ew_red = 1'b0; lamps_next.ew_green  = 1'b1; end
            ST_EW_YELLOW: begin lamps_next.ew_red = 1'b0; lamps_next.ew_yellow = 1'b1; end
            ST_PED_WALK:  lamps_next.walk = 1'b1;
            ST_FLASH: begin
                lamps_next = '0;
                if (state_reg != ST_FLASH) begin
                    lamps_next.ns_yellow = 1'b1;
                    lamps_next.ew_red    = 1'b1;
                end else if (tick) begin
                    lamps_next.ns_yellow = ~lamps_reg.ns_yellow;
                    lamps_next.ew_red    = ~lamps_reg.ew_red;
                end else begin
                    lamps_next.ns_yellow = lamps_reg.ns_yellow;
                    lamps_next.ew_red    = lamps_reg.ew_red;
                end
            end
            default: lamps_next = LAMPS_ALL_RED;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_ALL_RED;
            next_dir_reg    <= DIR_NS;
            cnt_reg         <= '0;
            ped_pending_reg <= 1'b0;
            ped_ack         <= 1'b0;
            lamps_reg       <= LAMPS_ALL_RED;
        end else begin
            state_reg       <= state_next;
            next_dir_reg    <= next_dir_next;
            cnt_reg         <= cnt_next;
            ped_pending_reg <= ped_pending_next;
            ped_ack         <= ped_ack_next;
            lamps_reg       <= lamps_next;
        end
    end

    assign ns_red    = lamps_reg.ns_red;
    assign ns_yellow = lamps_reg.ns_yellow;
    assign ns_green  = lamps_reg.ns_green;
    assign ew_red    = lamps_reg.ew_red;
    assign ew_yellow = lamps_reg.ew_yellow;
    assign ew_green  = lamps_reg.ew_green;
    assign walk      = lamps_reg.walk;
    assign phase     = state_reg;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: a countdown phase model drives per-cycle checks
// on a TICK_DIV=1 instance; a TICK_DIV=4 instance checks phase lengths in clocks.
module tb_traffic_light_ctrl;
    import traffic_light_ctrl_pkg::*;

    localparam int G_T  = 4;
    localparam int Y_T  = 2;
    localparam int AR_T = 1;
    localparam int PW_T = 6;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ped_req = 1'b0;
    logic flash_mode = 1'b0;

    logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_ack;
    logic [2:0] phase;
    logic ns_red4, ns_yellow4, ns_green4, ew_red4, ew_yellow4, ew_green4, walk4, ped_ack4;
    logic [2:0] phase4;

    logic [10:0] dut_vec;
    logic [10:0] reset_vec;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    traffic_light_ctrl #(.TICK_DIV(1)) dut (
        .clk(clk), .reset(reset), .ped_req(ped_req), .flash_mode(flash_mode),
        .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
        .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
        .walk(walk), .ped_ack(ped_ack), .phase(phase)
    );

    traffic_light_ctrl #(.TICK_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .ped_req(ped_req), .flash_mode(flash_mode),
        .ns_red(ns_red4), .ns_yellow(ns_yellow4), .ns_green(ns_green4),
        .ew_red(ew_red4), .ew_yellow(ew_yellow4), .ew_green(ew_green4),
        .walk(walk4), .ped_ack(ped_ack4), .phase(phase4)
    );

    assign dut_vec = {phase, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_ack};

    // Reference model: each cycle is a tick; phases count down remaining ticks.
    state_t m_state;
    int     m_left;
    bit     m_dir;
    bit     m_pend;
    bit     m_fl;
    bit     m_ack;
    bit     m_enter;
    bit     m_old_pend;
    state_t m_old;

    function automatic int dur_of(input state_t s);
        case (s)
            ST_NS_GREEN, ST_EW_GREEN:   return G_T;
            ST_NS_YELLOW, ST_EW_YELLOW: return Y_T;
            ST_PED_WALK:                return PW_T;
            default:                    return AR_T;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state = ST_ALL_RED; m_left = AR_T; m_dir = 0; m_pend = 0; m_fl = 1; m_ack = 0;
        end else begin
            m_enter = 0; m_old_pend = m_pend; m_old = m_state;
            if (m_state == ST_FLASH) begin
                if (!flash_mode) begin
                    m_state = ST_ALL_RED; m_left = AR_T; m_dir = 0;
                end else begin
                    m_fl = ~m_fl;
                end
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    case (m_state)
                        ST_NS_GREEN:  m_state = ST_NS_YELLOW;
                        ST_NS_YELLOW: begin m_state = ST_ALL_RED; m_dir = 1; end
                        ST_EW_GREEN:  m_state = ST_EW_YELLOW;
                        ST_EW_YELLOW: begin m_state = ST_ALL_RED; m_dir = 0; end
                        ST_PED_WALK:  m_state = m_dir ? ST_EW_GREEN : ST_NS_GREEN;
                        default: begin
                            if (flash_mode) begin
                                m_state = ST_FLASH; m_fl = 1;
                            end else if (m_old_pend) begin
                                m_state = ST_PED_WALK; m_enter = 1;
                            end else begin
                                m_state = m_dir ? ST_EW_GREEN : ST_NS_GREEN;
                            end
                        end
                    endcase
                    m_left = dur_of(m_state);
                end
            end
            if (m_enter) m_pend = 0;
            else if (ped_req && m_old != ST_PED_WALK) m_pend = 1;
            m_ack = m_enter;
        end
    end

    // Lamp order: ns_r ns_y ns_g ew_r ew_y ew_g walk
    function automatic logic [10:0] exp_vec();
        logic [6:0] l;
        case (m_state)
            ST_NS_GREEN:  l = 7'b0011000;
            ST_NS_YELLOW: l = 7'b0101000;
            ST_EW_GREEN:  l = 7'b1000010;
            ST_EW_YELLOW: l = 7'b1000100;
            ST_PED_WALK:  l = 7'b1001001;
            ST_FLASH:     l = {1'b0, m_fl, 1'b0, m_fl, 3'b000};
            default:      l = 7'b1001000;
        endcase
        return {3'(m_state), l, m_ack};
    endfunction

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b0; ped_req = 1'b0; flash_mode = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_phase(input state_t s, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (phase == s) ok = 1;
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL wait_phase got=%0d required=%0d within %0d cycles", phase, s, budget);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0; ped_req = 1'b0; flash_mode = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (dut_vec !== reset_vec) begin
            n_err++; $display("FAIL reset_state got=%b required=%b", dut_vec, reset_vec);
        end
        n_cmp++;
        if ({phase4, ns_red4, ew_red4, ns_green4, ew_green4, walk4} !== {3'd2, 2'b11, 3'b000}) begin
            n_err++; $display("FAIL reset_state_div4 phase=%0d ns_red=%b ew_red=%b required phase=2 reds=1", phase4, ns_red4, ew_red4);
        end
        reset = 1'b1;
    endtask

    task automatic test_free_run();
        int ng = 0;
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_err++; $display("FAIL free_run cyc=%0d got=%b required=%b", i, dut_vec, exp_vec());
            end
            if (phase == ST_NS_GREEN) ng++;
        end
        n_cmp++;
        if (ng !== 2 * G_T) begin
            n_err++; $display("FAIL free_run_ns_green_cycles got=%0d required=%0d", ng, 2 * G_T);
        end
    endtask

    task automatic test_ped_walk();
        bit ok;
        int walk_cnt = 0, ack_cnt = 0;
        state_t after_walk = ST_FLASH;
        bit was_walk = 0;
        reset_dut();
        wait_phase(ST_NS_GREEN, 10, ok);
        @(negedge clk);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_err++; $display("FAIL ped_walk cyc=%0d got=%b required=%b", i, dut_vec, exp_vec());
            end
            if (walk) walk_cnt++;
            if (ped_ack) ack_cnt++;
            if (was_walk && !walk && after_walk == ST_FLASH) after_walk = state_t'(phase);
            was_walk = walk;
        end
        n_cmp++;
        if (walk_cnt !== PW_T) begin
            n_err++; $display("FAIL ped_walk_len got=%0d required=%0d", walk_cnt, PW_T);
        end
        n_cmp++;
        if (ack_cnt !== 1) begin
            n_err++; $display("FAIL ped_ack_pulses got=%0d required=1", ack_cnt);
        end
        n_cmp++;
        if (after_walk !== ST_EW_GREEN) begin
            n_err++; $display("FAIL ped_exit_phase got=%0d required=%0d", after_walk, ST_EW_GREEN);
        end
    endtask

    task automatic test_flash();
        bit ok;
        bit saw_yellow = 0, saw_flash = 0, saw_ng = 0;
        reset_dut();
        wait_phase(ST_EW_GREEN, 20, ok);
        flash_mode = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_err++; $display("FAIL flash_on cyc=%0d got=%b required=%b", i, dut_vec, exp_vec());
            end
            if (phase == ST_EW_YELLOW) saw_yellow = 1;
            if (phase == ST_FLASH) saw_flash = 1;
        end
        flash_mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_err++; $display("FAIL flash_off cyc=%0d got=%b required=%b", i, dut_vec, exp_vec());
            end
            if (phase == ST_NS_GREEN) saw_ng = 1;
        end
        n_cmp++;
        if ({saw_yellow, saw_flash, saw_ng} !== 3'b111) begin
            n_err++; $display("FAIL flash_sequence got yellow/flash/ns_green=%b required=111", {saw_yellow, saw_flash, saw_ng});
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        reset_dut();
        wait_phase(ST_NS_YELLOW, 20, ok);
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if (dut_vec !== reset_vec) begin
            n_err++; $display("FAIL async_reset got=%b required=%b", dut_vec, reset_vec);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_err++; $display("FAIL after_reset cyc=%0d got=%b required=%b", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_tick_div();
        int ng_len = 0, ny_len = 0, eg_len = 0;
        bit ng_done = 0, ny_done = 0, eg_done = 0;
        reset_dut();
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (phase4 == ST_NS_GREEN && !ng_done) ng_len++;
            else if (ng_len > 0) ng_done = 1;
            if (phase4 == ST_NS_YELLOW && !ny_done) ny_len++;
            else if (ny_len > 0) ny_done = 1;
            if (phase4 == ST_EW_GREEN && !eg_done) eg_len++;
            else if (eg_len > 0) eg_done = 1;
        end
        n_cmp++;
        if (ng_len !== 4 * G_T) begin
            n_err++; $display("FAIL div4_ns_green_clks got=%0d required=%0d", ng_len, 4 * G_T);
        end
        n_cmp++;
        if (ny_len !== 4 * Y_T) begin
            n_err++; $display("FAIL div4_ns_yellow_clks got=%0d required=%0d", ny_len, 4 * Y_T);
        end
        n_cmp++;
        if (eg_len !== 4 * G_T) begin
            n_err++; $display("FAIL div4_ew_green_clks got=%0d required=%0d", eg_len, 4 * G_T);
        end
    endtask

    task automatic test_ped_and_flash();
        bit ok;
        bit saw_flash = 0, walk_before_flash = 0, saw_walk = 0;
        state_t after_walk = ST_FLASH;
        bit was_walk = 0;
        reset_dut();
        wait_phase(ST_NS_GREEN, 10, ok);
        ped_req = 1'b1; flash_mode = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_err++; $display("FAIL ped_flash_on cyc=%0d got=%b required=%b", i, dut_vec, exp_vec());
            end
            if (phase == ST_FLASH) saw_flash = 1;
            if (walk && !saw_flash) walk_before_flash = 1;
        end
        flash_mode = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_err++; $display("FAIL ped_flash_off cyc=%0d got=%b required=%b", i, dut_vec, exp_vec());
            end
            if (walk) saw_walk = 1;
            if (was_walk && !walk && after_walk == ST_FLASH) after_walk = state_t'(phase);
            was_walk = walk;
        end
        n_cmp++;
        if ({saw_flash, walk_before_flash, saw_walk} !== 3'b101) begin
            n_err++; $display("FAIL ped_flash_order got flash/early_walk/walk=%b required=101", {saw_flash, walk_before_flash, saw_walk});
        end
        n_cmp++;
        if (after_walk !== ST_NS_GREEN) begin
            n_err++; $display("FAIL ped_flash_exit got=%0d required=%0d", after_walk, ST_NS_GREEN);
        end
    endtask

    task automatic test_random();
        reset_dut();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_err++; $display("FAIL random cyc=%0d got=%b required=%b", i, dut_vec, exp_vec());
            end
            ped_req = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 59) == 0) flash_mode = ~flash_mode;
        end
        flash_mode = 1'b0; ped_req = 1'b0;
    endtask

    initial begin
        reset_vec = {3'd2, 7'b1001000, 1'b0};
        test_reset();
        test_free_run();
        test_ped_walk();
        test_flash();
        test_async_reset();
        test_tick_div();
        test_ped_and_flash();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
